// File: rtl/axis_video_timing_out.sv
// AXI4-Stream RGB to raster video: free-running timing counters and a
// SEEK/WAIT_FRM/RUN stream aligner with underflow and SOF/EOL error reporting.
module axis_video_timing_out #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  input  logic                            S_AXIS_TUSER,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] vid_data,
  output logic                            vid_de,
  output logic                            vid_hs,
  output logic                            vid_vs,
  output logic                            locked,
  output logic                            underflow,
  output logic                            sync_err
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {StSeek, StWaitFrm, StRun} state_e;

  state_e                          state_q, state_d;
  logic [HW-1:0]                   h_cnt_q, h_cnt_d;
  logic [VW-1:0]                   v_cnt_q, v_cnt_d;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic                            de_q, hs_q, vs_q, uf_q, se_q;
  logic                            h_wrap, v_wrap, de_c, hs_c, vs_c, sof_pos, eol_pos;
  logic                            tready, pix_ok, uf_c, err_c;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
    de_c    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_c    = (h_cnt_q >= H_HS_BEG) && (h_cnt_q < H_HS_END);
    vs_c    = (v_cnt_q >= V_VS_BEG) && (v_cnt_q < V_VS_END);
    sof_pos = (h_cnt_q == '0) && (v_cnt_q == '0);
    eol_pos = (h_cnt_q == H_EOL);
  end

  always_comb begin
    state_d = state_q;
    tready  = 1'b0;
    pix_ok  = 1'b0;
    uf_c    = 1'b0;
    err_c   = 1'b0;
    unique case (state_q)
      StSeek: begin
        // Drop everything up to the SOF beat, which is held for the frame boundary.
        tready = ~S_AXIS_TUSER;
        if (S_AXIS_TVALID && S_AXIS_TUSER) begin
          state_d = StWaitFrm;
        end
      end
      StWaitFrm: begin
        if (h_wrap && v_wrap) begin
          state_d = StRun;
        end
      end
      StRun: begin
        tready = de_c;
        if (de_c && S_AXIS_TVALID) begin
          if ((S_AXIS_TUSER != sof_pos) || (S_AXIS_TLAST != eol_pos)) begin
            err_c   = 1'b1;
            state_d = StSeek;
          end else begin
            pix_ok = 1'b1;
          end
        end else if (de_c) begin
          uf_c = 1'b1;
        end
      end
      default: state_d = StSeek;
    endcase
    data_d = pix_ok ? S_AXIS_TDATA : '0;
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q <= StSeek;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      data_q  <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      uf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      data_q  <= data_d;
      de_q    <= de_c;
      hs_q    <= hs_c ? HS_POL : ~HS_POL;
      vs_q    <= vs_c ? VS_POL : ~VS_POL;
      uf_q    <= uf_c;
      se_q    <= err_c;
    end
  end

  assign S_AXIS_TREADY = tready;
  assign vid_data      = data_q;
  assign vid_de        = de_q;
  assign vid_hs        = hs_q;
  assign vid_vs        = vs_q;
  assign underflow     = uf_q;
  assign sync_err      = se_q;
  assign locked        = (state_q == StRun);

endmodule

// File: tb/tb_axis_video_timing_out.sv
// Bench for axis_video_timing_out on a 14x7 raster: per-cycle raster/stream model
// plus hand-computed checkpoints; a second instance covers active-low syncs.
module tb_axis_video_timing_out;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast;
  logic        tready, de, hs, vs, lck, uf, se;
  logic [23:0] vdata;
  logic        tready2, de2, hs2, vs2, lck2, uf2, se2;
  logic [23:0] vdata2;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  axis_video_timing_out #(
    .C_S_AXIS_TDATA_WIDTH(24),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TUSER(tuser), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready), .vid_data(vdata), .vid_de(de), .vid_hs(hs),
    .vid_vs(vs), .locked(lck), .underflow(uf), .sync_err(se)
  );

  axis_video_timing_out #(
    .C_S_AXIS_TDATA_WIDTH(24),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_neg (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TUSER(tuser), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready2), .vid_data(vdata2), .vid_de(de2), .vid_hs(hs2),
    .vid_vs(vs2), .locked(lck2), .underflow(uf2), .sync_err(se2)
  );

  typedef struct {
    logic        gap;
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t q[$];

  typedef enum {MSeek, MWait, MRun} mmode_e;
  int          m_k;
  mmode_e      m_mode;
  logic        e_de, e_hs, e_vs, e_uf, e_se;
  logic [23:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, m_k);
    end
  endtask

  // Raster position is derived from the cycle count since reset release.
  task automatic model_step();
    int   h, v;
    logic act;
    if (rst) begin
      m_k = 0; m_mode = MSeek;
      e_de = 0; e_hs = 0; e_vs = 0; e_uf = 0; e_se = 0; e_data = '0;
    end else begin
      h = m_k % HT;
      v = (m_k / HT) % VT;
      act = (h < HA) && (v < VA);
      e_de = act;
      e_hs = (h >= HA + HF) && (h < HA + HF + HSY);
      e_vs = (v >= VA + VF) && (v < VA + VF + VSY);
      e_data = '0; e_uf = 0; e_se = 0;
      case (m_mode)
        MSeek: if (tvalid && tuser) m_mode = MWait;
        MWait: if (h == HT - 1 && v == VT - 1) m_mode = MRun;
        default: begin
          if (act) begin
            if (!tvalid) e_uf = 1;
            else if ((tuser != (h == 0 && v == 0)) || (tlast != (h == HA - 1))) begin
              e_se = 1; m_mode = MSeek;
            end else e_data = tdata;
          end
        end
      endcase
      m_k++;
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Stream source: gap entries withhold TVALID for one ready cycle.
  initial begin
    tvalid = 0; tuser = 0; tlast = 0; tdata = '0;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        tvalid = 0; tuser = 0; tlast = 0; tdata = '0;
      end else begin
        tvalid = !q[0].gap;
        tuser  = q[0].gap ? 1'b0 : q[0].user;
        tlast  = q[0].gap ? 1'b0 : q[0].last;
        tdata  = q[0].gap ? 24'h0 : q[0].data;
      end
      #1;
      if (!rst && q.size() > 0 && tready) void'(q.pop_front());
    end
  end

  initial begin
    int   h, v;
    logic e_rdy;
    forever begin
      @(negedge clk);
      #2;
      h = m_k % HT;
      v = (m_k / HT) % VT;
      case (m_mode)
        MSeek:   e_rdy = !tuser;
        MWait:   e_rdy = 1'b0;
        default: e_rdy = (h < HA) && (v < VA);
      endcase
      chk("de", de, e_de);
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("data", vdata, e_data);
      chk("underflow", uf, e_uf);
      chk("sync_err", se, e_se);
      chk("locked", lck, m_mode == MRun);
      chk("tready", tready, e_rdy);
      chk("neg_hs", hs2, !e_hs);
      chk("neg_vs", vs2, !e_vs);
      chk("neg_de", de2, e_de);
    end
  end

  task automatic push_frame(input int base, input int first_y, input int short_y,
                            input int gap_y);
    beat_t b;
    int    len;
    for (int y = first_y; y < VA; y++) begin
      len = (y == short_y) ? HA - 1 : HA;
      for (int x = 0; x < len; x++) begin
        if (y == gap_y && x == 3) begin
          for (int g = 0; g < 3; g++) begin
            b.gap = 1; b.data = '0; b.user = 0; b.last = 0;
            q.push_back(b);
          end
        end
        b.gap = 0;
        b.data = 24'(base + y * 8 + x);
        b.user = (x == 0 && y == 0);
        b.last = (x == len - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    #4;
    rst = 1;
    q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic leave_reset();
    @(posedge clk);
    #5;
    rst = 0;
  endtask

  task automatic step_to(input int c);
    int guard = 0;
    do begin
      @(negedge clk);
      #3;
      guard++;
    end while (m_k != c && guard < 5000);
    chk("step_to_reached", m_k, c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Continuous valid frames from reset.
    enter_reset();
    chk("rst_hs", hs, 0);
    chk("rst_neg_hs", hs2, 1);
    push_frame(0, 0, -1, -1);
    push_frame(0, 0, -1, -1);
    leave_reset();
    step_to(10);  chk("t1_hs_lo", hs, 0); chk("t1_neg_hs_hi", hs2, 1);
    step_to(11);  chk("t1_hs_hi", hs, 1); chk("t1_neg_hs_lo", hs2, 0);
    step_to(13);  chk("t1_hs_off", hs, 0);
    step_to(71);  chk("t1_vs_hi", vs, 1);
    step_to(97);  chk("t1_unlocked", lck, 0);
    step_to(98);  chk("t1_locked", lck, 1);
    step_to(99);  chk("t1_first_de", de, 1); chk("t1_first_px", vdata, 0);
    step_to(118); chk("t1_px_5_1", vdata, 13);
    step_to(300);

    // Three idle beats in line 1, then the late TLAST resyncs.
    enter_reset();
    push_frame(0, 0, -1, 1);
    push_frame(0, 0, -1, -1);
    leave_reset();
    step_to(116); chk("t2_uf0", uf, 1); chk("t2_uf0_data", vdata, 0);
    step_to(118); chk("t2_uf2", uf, 1);
    step_to(120); chk("t2_sync_err", se, 1); chk("t2_lock_lost", lck, 0);
    step_to(196); chk("t2_relock", lck, 1);
    step_to(198); chk("t2_px1", vdata, 1);
    step_to(260);

    // Mid-frame start: headless beats dropped, SOF held until the wrap.
    enter_reset();
    push_frame(0, 2, -1, -1);
    push_frame(24'h100, 0, -1, -1);
    leave_reset();
    step_to(1);  chk("t3_drop_rdy", tready, 1);
    step_to(30); chk("t3_sof_held", tready, 0);
    step_to(97); chk("t3_wait_rdy", tready, 0); chk("t3_unlocked", lck, 0);
    step_to(99); chk("t3_sof_px", vdata, 24'h100); chk("t3_sof_de", de, 1);
    step_to(200);

    // Short line: TLAST one pixel early.
    enter_reset();
    push_frame(0, 0, 1, -1);
    push_frame(0, 0, -1, -1);
    leave_reset();
    step_to(119); chk("t4_sync_err", se, 1); chk("t4_lock_lost", lck, 0);
    chk("t4_data_zero", vdata, 0);
    step_to(250);

    // Asynchronous reset in the middle of active video.
    enter_reset();
    push_frame(0, 0, -1, -1);
    push_frame(0, 0, -1, -1);
    leave_reset();
    step_to(115); chk("t5_pre_de", de, 1);
    #1;
    rst = 1;
    #1;
    chk("t5_de", de, 0); chk("t5_hs", hs, 0); chk("t5_vs", vs, 0);
    chk("t5_data", vdata, 0); chk("t5_locked", lck, 0); chk("t5_neg_hs", hs2, 1);
    q.delete();
    repeat (2) @(posedge clk);
    push_frame(0, 0, -1, -1);
    leave_reset();
    step_to(98); chk("t5_relock", lck, 1);
    step_to(120);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
